// File: rtl/fmp_pkg.sv
// Shared definitions for the multi-phase offset path: default widths, segment count, nominal boundaries.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package fmp_pkg;

  localparam int WF_PHASE_DEF   = 24;
  localparam int MP_SEG_BIN_DEF = 1;

  // Number of multi-phase segments for a given log2 count.
  function automatic int mp_seg(input int seg_bin);
    return 1 << seg_bin;
  endfunction

  // Nominal upper boundary of segment k: equal-width split of the phase circle.
  // Returned wide; callers truncate to their phase width, so the top word wraps to 0.
  function automatic logic [63:0] nominal_bnd(input int k, input int wf_phase, input int seg_bin);
    return 64'(k + 1) << (wf_phase - seg_bin);
  endfunction

endpackage

// File: rtl/fmp_seg_quant.sv
// Combinational priority-scan quantizer: maps a phase onto a segment of the boundary array.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: phase (in), seg_arr (in, word k = upper boundary of segment k, top word ignored),
//        sel (out, segment index), lo / hi (out, segment bounds; hi=0 on the top segment means full scale).
module fmp_seg_quant
  import fmp_pkg::*;
#(
  parameter int  WF_PHASE   = WF_PHASE_DEF,
  parameter int  MP_SEG_BIN = MP_SEG_BIN_DEF,
  localparam int MP_SEG     = 1 << MP_SEG_BIN
) (
  input  logic [WF_PHASE-1:0]        phase,
  input  logic [MP_SEG*WF_PHASE-1:0] seg_arr,
  output logic [MP_SEG_BIN-1:0]      sel,
  output logic [WF_PHASE-1:0]        lo,
  output logic [WF_PHASE-1:0]        hi
);

  localparam logic [MP_SEG_BIN-1:0] TOP_SEL = MP_SEG_BIN'(MP_SEG - 1);

  logic [WF_PHASE-1:0] bnd [MP_SEG];

  for (genvar g = 0; g < MP_SEG; g++) begin : g_unpack
    assign bnd[g] = seg_arr[g*WF_PHASE +: WF_PHASE];
  end

  always_comb begin
    sel = TOP_SEL;
    // Scan downward so the lowest matching boundary wins; this keeps the result
    // deterministic even when a miscalibrated array is not monotonic.
    for (int k = MP_SEG - 2; k >= 0; k--) begin
      if (phase < bnd[k]) begin
        sel = MP_SEG_BIN'(k);
      end
    end
    lo = '0;
    hi = '0;
    if (sel != '0) begin
      lo = bnd[sel - MP_SEG_BIN'(1)];
    end
    // Top segment ends at full scale, represented as 0 in modulo arithmetic.
    if (sel != TOP_SEL) begin
      hi = bnd[sel];
    end
  end

endmodule

// File: rtl/fmp_phase_seg_map.sv
// Fractional phase accumulator + segment quantizer feeding the multi-phase mux and DTC gain.
// Latency: PHASE_ACC 1 cycle after FCW; MP_SEL/PHASE_RES/SEG_W/WRAP one cycle after PHASE_ACC.
// Backpressure: none; EN low freezes all state and drops VLD on the next edge.
// Ports: CLK, NRST (async active-low), EN, FCW_FRAC, DPHASE_SEG_ARR (boundary words) in;
//        PHASE_ACC, MP_SEL, PHASE_RES, SEG_W, WRAP, VLD out.
module fmp_phase_seg_map
  import fmp_pkg::*;
#(
  parameter int  WF_PHASE   = WF_PHASE_DEF,
  parameter int  MP_SEG_BIN = MP_SEG_BIN_DEF,
  localparam int MP_SEG     = 1 << MP_SEG_BIN
) (
  input  logic                       CLK,
  input  logic                       NRST,
  input  logic                       EN,
  input  logic [WF_PHASE-1:0]        FCW_FRAC,
  input  logic [MP_SEG*WF_PHASE-1:0] DPHASE_SEG_ARR,
  output logic [WF_PHASE-1:0]        PHASE_ACC,
  output logic [MP_SEG_BIN-1:0]      MP_SEL,
  output logic [WF_PHASE-1:0]        PHASE_RES,
  output logic [WF_PHASE-1:0]        SEG_W,
  output logic                       WRAP,
  output logic                       VLD
);

  function automatic logic [MP_SEG*WF_PHASE-1:0] shadow_rst_val();
    logic [MP_SEG*WF_PHASE-1:0] v;
    v = '0;
    for (int k = 0; k < MP_SEG; k++) begin
      v[k*WF_PHASE +: WF_PHASE] = WF_PHASE'(nominal_bnd(k, WF_PHASE, MP_SEG_BIN));
    end
    return v;
  endfunction

  localparam logic [MP_SEG*WF_PHASE-1:0] SHADOW_RST = shadow_rst_val();
  localparam logic [WF_PHASE-1:0]        SEG_W_RST  = WF_PHASE'(nominal_bnd(0, WF_PHASE, MP_SEG_BIN));

  // Stage 0 state
  logic [WF_PHASE-1:0]        acc_q, acc_d;
  logic                       wrap0_q, wrap0_d;
  logic                       en_d_q, en_d_d;
  logic [MP_SEG*WF_PHASE-1:0] shadow_q, shadow_d;
  // Stage 1 state
  logic [MP_SEG_BIN-1:0]      sel_q, sel_d;
  logic [WF_PHASE-1:0]        res_q, res_d;
  logic [WF_PHASE-1:0]        segw_q, segw_d;
  logic                       wrap_q, wrap_d;
  logic                       vld_q, vld_d;

  logic [WF_PHASE:0]          acc_sum;
  logic [MP_SEG_BIN-1:0]      q_sel;
  logic [WF_PHASE-1:0]        q_lo;
  logic [WF_PHASE-1:0]        q_hi;

  // Quantizes the registered accumulator against the registered shadow, so the
  // sample taken on a wrap edge already sees the boundaries loaded on that edge.
  fmp_seg_quant #(
    .WF_PHASE  (WF_PHASE),
    .MP_SEG_BIN(MP_SEG_BIN)
  ) u_quant (
    .phase  (acc_q),
    .seg_arr(shadow_q),
    .sel    (q_sel),
    .lo     (q_lo),
    .hi     (q_hi)
  );

  always_comb begin
    acc_sum  = {1'b0, acc_q} + {1'b0, FCW_FRAC};
    acc_d    = acc_q;
    wrap0_d  = wrap0_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    res_d    = res_q;
    segw_d   = segw_q;
    wrap_d   = wrap_q;
    en_d_d   = EN;
    vld_d    = en_d_q & EN;
    if (EN) begin
      acc_d   = acc_sum[WF_PHASE-1:0];
      wrap0_d = acc_sum[WF_PHASE];
      // Boundaries only change at a period start (carry) or when the block wakes,
      // so one accumulator period is always quantized against a single array.
      if (acc_sum[WF_PHASE] || !en_d_q) begin
        shadow_d = DPHASE_SEG_ARR;
      end
      sel_d  = q_sel;
      res_d  = acc_q - q_lo;
      segw_d = q_hi - q_lo;
      wrap_d = wrap0_q;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      acc_q    <= '0;
      wrap0_q  <= 1'b0;
      en_d_q   <= 1'b0;
      shadow_q <= SHADOW_RST;
      sel_q    <= '0;
      res_q    <= '0;
      segw_q   <= SEG_W_RST;
      wrap_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      wrap0_q  <= wrap0_d;
      en_d_q   <= en_d_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      res_q    <= res_d;
      segw_q   <= segw_d;
      wrap_q   <= wrap_d;
      vld_q    <= vld_d;
    end
  end

  assign PHASE_ACC = acc_q;
  assign MP_SEL    = sel_q;
  assign PHASE_RES = res_q;
  assign SEG_W     = segw_q;
  assign WRAP      = wrap_q;
  assign VLD       = vld_q;

endmodule

// File: tb/tb_fmp_phase_seg_map.sv
// Bench for fmp_phase_seg_map: directed scenarios plus randomized traffic against a phase-circle model.
// A second 4-segment instance is checked against a closed-form accumulation sequence.
module tb_fmp_phase_seg_map;

  localparam logic [63:0] MASK = 64'hFFFFFF;
  localparam logic [63:0] FS   = 64'h1000000;

  logic        CLK, NRST, EN;
  logic [23:0] FCW_FRAC;
  logic [47:0] ARR;
  logic [23:0] PHASE_ACC, PHASE_RES, SEG_W;
  logic [0:0]  MP_SEL;
  logic        WRAP, VLD;

  logic        EN2;
  logic [23:0] FCW2;
  logic [95:0] ARR2;
  logic [23:0] PHASE_ACC2, PHASE_RES2, SEG_W2;
  logic [1:0]  MP_SEL2;
  logic        WRAP2, VLD2;

  fmp_phase_seg_map #(.WF_PHASE(24), .MP_SEG_BIN(1)) dut (
    .CLK(CLK), .NRST(NRST), .EN(EN), .FCW_FRAC(FCW_FRAC), .DPHASE_SEG_ARR(ARR),
    .PHASE_ACC(PHASE_ACC), .MP_SEL(MP_SEL), .PHASE_RES(PHASE_RES), .SEG_W(SEG_W),
    .WRAP(WRAP), .VLD(VLD)
  );

  fmp_phase_seg_map #(.WF_PHASE(24), .MP_SEG_BIN(2)) dut4 (
    .CLK(CLK), .NRST(NRST), .EN(EN2), .FCW_FRAC(FCW2), .DPHASE_SEG_ARR(ARR2),
    .PHASE_ACC(PHASE_ACC2), .MP_SEL(MP_SEL2), .PHASE_RES(PHASE_RES2), .SEG_W(SEG_W2),
    .WRAP(WRAP2), .VLD(VLD2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference quantizer on the true phase circle: top segment ends at FS (2^24).
  function automatic void ref_quant(input logic [63:0] ph, input logic [63:0] b[4], input int n,
                                    output int s, output logic [63:0] lo, output logic [63:0] hi);
    s = -1;
    for (int k = 0; k < n - 1; k++) begin
      if (s < 0 && ph < b[k]) s = k;
    end
    if (s < 0) s = n - 1;
    lo = (s == 0) ? 64'd0 : b[s-1];
    hi = (s == n - 1) ? FS : b[s];
  endfunction

  // Model of the 2-segment instance
  logic [63:0] m_acc, m_wrap0, m_sel, m_res, m_segw, m_wrap, m_vld;
  logic [63:0] m_sh [4];
  bit          m_en_prev;

  task automatic model_reset();
    m_acc = 0; m_wrap0 = 0; m_sel = 0; m_res = 0; m_wrap = 0; m_vld = 0;
    m_segw = FS >> 1;
    m_sh[0] = FS >> 1; m_sh[1] = FS & MASK; m_sh[2] = 0; m_sh[3] = 0;
    m_en_prev = 1'b0;
  endtask

  task automatic model_edge();
    int s;
    logic [63:0] lo, hi, sum;
    if (EN) begin
      ref_quant(m_acc, m_sh, 2, s, lo, hi);
      m_sel  = 64'(s);
      m_res  = (m_acc - lo) & MASK;
      m_segw = (hi - lo) & MASK;
      m_wrap = m_wrap0;
      sum = m_acc + 64'(FCW_FRAC);
      if (sum >= FS || !m_en_prev) begin
        m_sh[0] = 64'(ARR[23:0]);
        m_sh[1] = 64'(ARR[47:24]);
      end
      m_wrap0 = (sum >= FS) ? 64'd1 : 64'd0;
      m_acc   = sum & MASK;
    end
    m_vld = (m_en_prev && EN) ? 64'd1 : 64'd0;
    m_en_prev = EN;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".acc"},  64'(PHASE_ACC), m_acc);
    chk({ph, ".sel"},  64'(MP_SEL),    m_sel);
    chk({ph, ".res"},  64'(PHASE_RES), m_res);
    chk({ph, ".segw"}, 64'(SEG_W),     m_segw);
    chk({ph, ".wrap"}, 64'(WRAP),      m_wrap);
    chk({ph, ".vld"},  64'(VLD),       m_vld);
  endtask

  task automatic step(input string ph);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic arst_pulse(input string ph);
    #2 NRST = 1'b0;
    #1 model_reset();
    check_all(ph);
    #1 NRST = 1'b1;
  endtask

  logic [23:0] t_acc  [5] = '{24'h400000, 24'h800000, 24'hC00000, 24'h000000, 24'h400000};
  logic [23:0] t_res  [5] = '{24'h000000, 24'h400000, 24'h000000, 24'h400000, 24'h000000};
  logic        t_sel  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        t_wrap [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [63:0] b2 [4];
    logic [63:0] ph, lo, hi, f;
    int s, m;

    NRST = 1'b0; EN = 1'b0; FCW_FRAC = '0; ARR = {24'h000000, 24'h800000};
    EN2 = 1'b0; FCW2 = '0; ARR2 = '0;
    model_reset();
    #12;
    check_all("rst");
    chk("rst4.segw", 64'(SEG_W2), 64'h400000);
    chk("rst4.vld",  64'(VLD2),   64'd0);
    NRST = 1'b1;

    // Nominal sweep
    EN = 1'b1; FCW_FRAC = 24'h400000;
    for (int i = 0; i < 5; i++) begin
      step("nom");
      chk("nom.acc_tbl", 64'(PHASE_ACC), 64'(t_acc[i]));
      chk("nom.vld_tbl", 64'(VLD), (i >= 1) ? 64'd1 : 64'd0);
      if (i >= 1) begin
        chk("nom.sel_tbl",  64'(MP_SEL),    64'(t_sel[i]));
        chk("nom.res_tbl",  64'(PHASE_RES), 64'(t_res[i]));
        chk("nom.wrap_tbl", 64'(WRAP),      64'(t_wrap[i]));
        chk("nom.segw_tbl", 64'(SEG_W),     64'h800000);
      end
    end

    // Boundary change mid-period (acc currently 0x400000)
    ARR[23:0] = 24'h600000;
    for (int i = 0; i < 6; i++) begin
      step("mid");
      if (i == 1) begin
        chk("mid.old_sel", 64'(MP_SEL), 64'd1);
        chk("mid.old_res", 64'(PHASE_RES), 64'd0);
      end
      if (i == 5) begin
        chk("mid.new_sel",  64'(MP_SEL),    64'd1);
        chk("mid.new_res",  64'(PHASE_RES), 64'h200000);
        chk("mid.new_segw", 64'(SEG_W),     64'hA00000);
      end
    end

    // EN gating
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("gate_off");
      chk("gate_off.vld_low", 64'(VLD), 64'd0);
    end
    EN = 1'b1;
    for (int i = 0; i < 4; i++) step("gate_on");

    // Async reset while acc = 0xC00000
    for (int i = 0; i < 8; i++) begin
      if (m_acc != 64'hC00000) step("pre_rst");
    end
    chk("arst.pre_acc", 64'(PHASE_ACC), 64'hC00000);
    arst_pulse("arst");
    step("post_rst");
    chk("post_rst.acc", 64'(PHASE_ACC), 64'h400000);

    // Step of 1 LSB across the first boundary
    ARR = {24'h000000, 24'h800000};
    FCW_FRAC = 24'h7FFFFF;
    arst_pulse("lsb_rst");
    step("lsb_pre");
    FCW_FRAC = 24'h000001;
    step("lsb0");
    chk("lsb0.sel", 64'(MP_SEL),    64'd0);
    chk("lsb0.res", 64'(PHASE_RES), 64'h7FFFFF);
    step("lsb1");
    chk("lsb1.sel", 64'(MP_SEL),    64'd1);
    chk("lsb1.res", 64'(PHASE_RES), 64'd0);

    // Zero increment: everything holds, no wrap
    FCW_FRAC = 24'h000000;
    for (int i = 0; i < 4; i++) step("fcw0");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      EN = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: FCW_FRAC = 24'($urandom_range(0, 16));
        1: FCW_FRAC = 24'hFFFFFF - 24'($urandom_range(0, 16));
        default: FCW_FRAC = 24'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) ARR = {24'($urandom), 24'($urandom)};
      if ($urandom_range(0, 99) == 0) arst_pulse("rnd_rst");
      step("rnd");
    end

    // 4-segment instance, non-monotonic boundaries, closed-form phase sequence
    EN = 1'b0;
    ARR2 = {24'h123456, 24'hC00000, 24'h400000, 24'h800000};
    b2[0] = 64'h800000; b2[1] = 64'h400000; b2[2] = 64'hC00000; b2[3] = 64'h123456;
    f = 64'h500000;
    FCW2 = 24'h500000;
    EN2 = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(posedge CLK);
      #1;
      chk("q4.acc", 64'(PHASE_ACC2), (64'(n) * f) & MASK);
      chk("q4.vld", 64'(VLD2), (n >= 2) ? 64'd1 : 64'd0);
      if (n >= 2) begin
        m  = n - 1;
        ph = (64'(m) * f) & MASK;
        ref_quant(ph, b2, 4, s, lo, hi);
        chk("q4.sel",  64'(MP_SEL2),    64'(s));
        chk("q4.res",  64'(PHASE_RES2), (ph - lo) & MASK);
        chk("q4.segw", 64'(SEG_W2),     (hi - lo) & MASK);
        chk("q4.wrap", 64'(WRAP2),
            (((64'(m) * f) >> 24) != ((64'(m - 1) * f) >> 24)) ? 64'd1 : 64'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
